// File: rtl/dds_pkg.sv
// Shared constants and sine-table generators for the DDS core.
// Latency: n/a (package; functions are evaluated at elaboration to build ROM contents).
// Backpressure: n/a.
package dds_pkg;

  localparam int         LUT_AW   = 8;
  localparam int         SAMPLE_W = 8;
  localparam logic [7:0] MIDSCALE = 8'd128;
  localparam int         AMPL     = 127;

  // Q[i] = round(127*sin(2*pi*i/256)), i = 0..64, rounded half away from zero.
  // Held as integer constants so the ROM contents are exact and tool-independent.
  function automatic logic [6:0] quarter_sin(input logic [6:0] i);
    logic [6:0] q;
    case (i)
      7'd0:  q = 7'd0;    7'd1:  q = 7'd3;    7'd2:  q = 7'd6;    7'd3:  q = 7'd9;
      7'd4:  q = 7'd12;   7'd5:  q = 7'd16;   7'd6:  q = 7'd19;   7'd7:  q = 7'd22;
      7'd8:  q = 7'd25;   7'd9:  q = 7'd28;   7'd10: q = 7'd31;   7'd11: q = 7'd34;
      7'd12: q = 7'd37;   7'd13: q = 7'd40;   7'd14: q = 7'd43;   7'd15: q = 7'd46;
      7'd16: q = 7'd49;   7'd17: q = 7'd51;   7'd18: q = 7'd54;   7'd19: q = 7'd57;
      7'd20: q = 7'd60;   7'd21: q = 7'd63;   7'd22: q = 7'd65;   7'd23: q = 7'd68;
      7'd24: q = 7'd71;   7'd25: q = 7'd73;   7'd26: q = 7'd76;   7'd27: q = 7'd78;
      7'd28: q = 7'd81;   7'd29: q = 7'd83;   7'd30: q = 7'd85;   7'd31: q = 7'd88;
      7'd32: q = 7'd90;   7'd33: q = 7'd92;   7'd34: q = 7'd94;   7'd35: q = 7'd96;
      7'd36: q = 7'd98;   7'd37: q = 7'd100;  7'd38: q = 7'd102;  7'd39: q = 7'd104;
      7'd40: q = 7'd106;  7'd41: q = 7'd107;  7'd42: q = 7'd109;  7'd43: q = 7'd111;
      7'd44: q = 7'd112;  7'd45: q = 7'd113;  7'd46: q = 7'd115;  7'd47: q = 7'd116;
      7'd48: q = 7'd117;  7'd49: q = 7'd118;  7'd50: q = 7'd120;  7'd51: q = 7'd121;
      7'd52: q = 7'd122;  7'd53: q = 7'd122;  7'd54: q = 7'd123;  7'd55: q = 7'd124;
      7'd56: q = 7'd125;  7'd57: q = 7'd125;  7'd58: q = 7'd126;  7'd59: q = 7'd126;
      7'd60: q = 7'd126;  7'd61: q = 7'd127;  7'd62: q = 7'd127;  7'd63: q = 7'd127;
      7'd64: q = 7'(AMPL);
      // Indices above 64 are never produced by the quadrant decode.
      default: q = 7'd0;
    endcase
    return q;
  endfunction

  // T[k] = 128 + round(127*sin(2*pi*k/256)), built from the quarter wave by symmetry.
  function automatic logic [7:0] full_sin(input logic [7:0] k);
    logic [7:0] mirror;
    logic [6:0] idx;
    logic [6:0] mag;
    mirror = 8'd128 - {1'b0, k[6:0]};
    idx    = k[6] ? mirror[6:0] : {1'b0, k[5:0]};
    mag    = quarter_sin(idx);
    return k[7] ? (MIDSCALE - {1'b0, mag}) : (MIDSCALE + {1'b0, mag});
  endfunction

endpackage

// File: rtl/dds_sin_rom.sv
// Registered 256-point sine lookup; DDS_QUARTER_WAVE_EN selects a 65-entry quarter-wave ROM.
// Latency: 1 cycle from address to value; reset forces value to mid-scale.
// Backpressure: none; a new address is accepted every cycle.
module dds_sin_rom
  import dds_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] address,
  output logic [7:0] value
);

  logic [7:0] value_q;
  logic [7:0] value_d;

`ifdef DDS_QUARTER_WAVE_EN
  logic [7:0] mirror_idx;
  logic [6:0] q_idx;
  logic [6:0] q_mag;

  // Fold the address into the first quadrant, look up the magnitude, restore the sign.
  // Quadrants 1 and 3 mirror as 128 - k[6:0]; quadrants 0 and 2 use k[5:0] directly.
  always_comb begin
    mirror_idx = 8'd128 - {1'b0, address[6:0]};
    q_idx      = address[6] ? mirror_idx[6:0] : {1'b0, address[5:0]};
    q_mag      = quarter_sin(q_idx);
    value_d    = address[7] ? (MIDSCALE - {1'b0, q_mag}) : (MIDSCALE + {1'b0, q_mag});
  end
`else
  logic [7:0] rom [256];

  for (genvar k = 0; k < 256; k++) begin : g_rom
    assign rom[k] = full_sin(8'(k));
  end

  // Flat table: the address indexes the full period directly.
  always_comb begin
    value_d = rom[address];
  end
`endif

  // Output register: mid-scale under reset, otherwise the looked-up sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q <= MIDSCALE;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/dds_core.sv
// DDS core: phase accumulator stepping by mult each cycle, driving a registered sine ROM.
// Latency: phase_acc registered; value lags phase_acc by 1 cycle (mult to value: 2 cycles).
// Backpressure: none; free-running every cycle. DDS_QUARTER_WAVE_EN selects the quarter-wave ROM.
module dds_core
  import dds_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ACC_W-1:0] mult,
  output logic [7:0]       phase_acc,
  output logic [OUT_W-1:0] value
);

  if (ACC_W < LUT_AW) begin : g_bad_acc_w
    $error("dds_core: ACC_W must be at least 8");
  end
  if (OUT_W != SAMPLE_W) begin : g_bad_out_w
    $error("dds_core: OUT_W must be 8 in this revision");
  end

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  // Next phase: modulo-2^ACC_W add, wrap is silent by design.
  always_comb begin
    acc_d = acc_q + mult;
  end

  // Phase accumulator register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign phase_acc = acc_q[ACC_W-1 -: LUT_AW];

  dds_sin_rom u_sin_rom (
    .clk     (clk),
    .reset   (reset),
    .address (phase_acc),
    .value   (value)
  );

endmodule

// File: tb/tb_dds_core.sv
// Directed bench for dds_core: reset hold, wrap sequence, full-period sweep, freeze, mid-run reset.
// Latency: samples outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_dds_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] mult;
  logic [7:0] phase_acc;
  logic [7:0] value;

  int checks = 0;
  int errors = 0;
  int m_acc;
  int m_val;
  int hand_val [16] = '{128, 177, 218, 245, 255, 245, 218, 177,
                        128,  79,  38,  11,   1,  11,  38,  79};

  dds_core #(.ACC_W(8), .OUT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .mult      (mult),
    .phase_acc (phase_acc),
    .value     (value)
  );

  always #5 clk = ~clk;

  // Reference sine sample computed from real math, rounding half away from zero.
  function automatic int tref(input int k);
    real x;
    x = 127.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 256.0);
    if (x >= 0.0) return 128 + int'($floor(x + 0.5));
    else          return 128 - int'($floor(-x + 0.5));
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: update the reference model from the inputs seen at the edge, then settle.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m_acc = 0;
      m_val = 128;
    end else begin
      m_val = tref(m_acc);
      m_acc = (m_acc + int'(mult)) % 256;
    end
    #1;
  endtask

  initial begin
    reset = 1'b0;
    mult  = 8'd16;
    m_acc = 0;
    m_val = 128;

    // Reset held low: both outputs pinned.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("reset_phase", phase_acc, 8'd0);
      check("reset_value", value, 8'd128);
    end

    // Release with mult=16: phase steps by 16 and wraps; value trails one cycle.
    reset = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      check("wrap_phase", phase_acc, 8'((16 * n) % 256));
      check("wrap_value", value, 8'(hand_val[n-1]));
    end

    // Full-period sweep with mult=1 against the real-math table.
    mult = 8'd1;
    for (int n = 0; n < 257; n++) begin
      tick();
      check("sweep_phase", phase_acc, 8'(m_acc));
      check("sweep_value", value, 8'(m_val));
    end

    // Drive phase back to 0 then to 48 with mult=16, then freeze with mult=0.
    mult = 8'd255;
    tick();
    check("realign_phase", phase_acc, 8'd0);
    mult = 8'd16;
    for (int n = 0; n < 3; n++) tick();
    check("pre_freeze_phase", phase_acc, 8'd48);
    mult = 8'd0;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("freeze_phase", phase_acc, 8'd48);
      check("freeze_value", value, 8'd245);
    end

    // Resume, reach phase 96, then assert reset for one edge.
    mult = 8'd16;
    for (int n = 0; n < 3; n++) tick();
    check("pre_reset_phase", phase_acc, 8'd96);
    check("pre_reset_value", value, 8'd245);
    reset = 1'b0;
    tick();
    check("midrun_reset_phase", phase_acc, 8'd0);
    check("midrun_reset_value", value, 8'd128);
    reset = 1'b1;
    tick();
    check("restart_phase1", phase_acc, 8'd16);
    check("restart_value1", value, 8'd128);
    tick();
    check("restart_phase2", phase_acc, 8'd32);
    check("restart_value2", value, 8'd177);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
